// File: rtl/issue_pkg.sv
// Shared types and widths for the issue/execute boundary.
// Entries carried through the execution lanes use exec_entry_t.
package issue_pkg;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned BID_W   = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned LAT_MAX = 4;

  // Per-lane kill count covers at most LAT_MAX-1 shifting stages.
  localparam int unsigned KILL_W  = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ACC_W   = 5;
  localparam int unsigned CNT_MAX = 13;

  localparam logic [OP_W-1:0] OP_NODEST = 4'hF;

  typedef struct packed {
    logic             live;
    logic             wb;
    logic [REG_W-1:0] des;
    logic [BID_W-1:0] bid;
  } exec_entry_t;

  // True when a flush is active and targets this branch tag.
  function automatic logic bid_hit(input logic             en,
                                   input logic [BID_W-1:0] id,
                                   input logic [BID_W-1:0] bid);
    return en && (bid == id);
  endfunction

endpackage

// File: rtl/exec_lane_pipe.sv
// One fixed-latency execution lane: an LAT-deep shift pipeline whose last
// stage drives the completion port. Reports per-edge issue/retire/kill events.
module exec_lane_pipe
  import issue_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [REG_W-1:0]  i_des,
  input  logic [OP_W-1:0]   i_op,
  input  logic [BID_W-1:0]  i_bid,
  input  logic              i_flush_en,
  input  logic [BID_W-1:0]  i_flush_id,
  output logic              o_back_vld,
  output logic [REG_W-1:0]  o_back_des,
  output logic              o_issued_c,
  output logic              o_retired,
  output logic [KILL_W-1:0] o_flushed_c
);

  exec_entry_t       r_stage [LAT];
  exec_entry_t       w_next  [LAT];
  logic              w_kill_in;
  logic [KILL_W-1:0] w_flushed;

  // Next pipeline contents with flushed entries killed on their way in.
  always_comb begin
    w_next    = '{default: '0};
    w_flushed = '0;
    w_kill_in = bid_hit(i_flush_en, i_flush_id, i_bid);
    w_next[0] = '{live: i_vld && !w_kill_in,
                  wb:   (i_op != OP_NODEST),
                  des:  i_des,
                  bid:  i_bid};
    for (int unsigned s = 1; s < LAT; s++) begin
      w_next[s] = r_stage[s-1];
      if (r_stage[s-1].live && bid_hit(i_flush_en, i_flush_id, r_stage[s-1].bid)) begin
        w_next[s].live = 1'b0;
        w_flushed      = w_flushed + KILL_W'(1);
      end
    end
  end

  // Payload only loads with a live entry so the completion tag holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < LAT; s++) begin
        r_stage[s].live <= w_next[s].live;
        if (w_next[s].live) begin
          r_stage[s].wb  <= w_next[s].wb;
          r_stage[s].bid <= w_next[s].bid;
          if (w_next[s].wb) begin
            r_stage[s].des <= w_next[s].des;
          end
        end
      end
    end
  end

  assign o_back_vld  = r_stage[LAT-1].live && r_stage[LAT-1].wb;
  assign o_back_des  = r_stage[LAT-1].des;
  assign o_retired   = r_stage[LAT-1].live;
  assign o_issued_c  = w_next[0].live;
  assign o_flushed_c = w_flushed;

endmodule

// File: rtl/exec_writeback_stage.sv
// Four fixed-latency execution lanes feeding issue-stage wakeup, plus a
// live-entry counter and idle flag.
module exec_writeback_stage
  import issue_pkg::*;
#(
  parameter int unsigned LAT1 = 1,
  parameter int unsigned LAT2 = 1,
  parameter int unsigned LAT3 = 3,
  parameter int unsigned LAT4 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iq_out_1_vld,
  input  logic [REG_W-1:0] iq_out_1_des,
  input  logic [OP_W-1:0]  iq_out_1_op,
  input  logic [BID_W-1:0] iq_out_1_bid,
  input  logic             iq_out_2_vld,
  input  logic [REG_W-1:0] iq_out_2_des,
  input  logic [OP_W-1:0]  iq_out_2_op,
  input  logic [BID_W-1:0] iq_out_2_bid,
  input  logic             iq_out_3_vld,
  input  logic [REG_W-1:0] iq_out_3_des,
  input  logic [OP_W-1:0]  iq_out_3_op,
  input  logic [BID_W-1:0] iq_out_3_bid,
  input  logic             iq_out_4_vld,
  input  logic [REG_W-1:0] iq_out_4_des,
  input  logic [OP_W-1:0]  iq_out_4_op,
  input  logic [BID_W-1:0] iq_out_4_bid,
  input  logic             flush_en,
  input  logic [BID_W-1:0] flush_id,
  output logic             ins_back_1_vld,
  output logic [REG_W-1:0] ins_back_1_des,
  output logic             ins_back_2_vld,
  output logic [REG_W-1:0] ins_back_2_des,
  output logic             ins_back_3_vld,
  output logic [REG_W-1:0] ins_back_3_des,
  output logic             ins_back_4_vld,
  output logic [REG_W-1:0] ins_back_4_des,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             idle
);

  logic              w_vld      [4];
  logic [REG_W-1:0]  w_des      [4];
  logic [OP_W-1:0]   w_op       [4];
  logic [BID_W-1:0]  w_bid      [4];
  logic              w_back_vld [4];
  logic [REG_W-1:0]  w_back_des [4];
  logic              w_issued   [4];
  logic              w_retired  [4];
  logic [KILL_W-1:0] w_flushed  [4];
  logic [ACC_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  r_cnt;

  assign w_vld[0] = iq_out_1_vld;
  assign w_des[0] = iq_out_1_des;
  assign w_op[0]  = iq_out_1_op;
  assign w_bid[0] = iq_out_1_bid;
  assign w_vld[1] = iq_out_2_vld;
  assign w_des[1] = iq_out_2_des;
  assign w_op[1]  = iq_out_2_op;
  assign w_bid[1] = iq_out_2_bid;
  assign w_vld[2] = iq_out_3_vld;
  assign w_des[2] = iq_out_3_des;
  assign w_op[2]  = iq_out_3_op;
  assign w_bid[2] = iq_out_3_bid;
  assign w_vld[3] = iq_out_4_vld;
  assign w_des[3] = iq_out_4_des;
  assign w_op[3]  = iq_out_4_op;
  assign w_bid[3] = iq_out_4_bid;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    exec_lane_pipe #(
      .LAT((g == 0) ? LAT1 : (g == 1) ? LAT2 : (g == 2) ? LAT3 : LAT4)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_vld       (w_vld[g]),
      .i_des       (w_des[g]),
      .i_op        (w_op[g]),
      .i_bid       (w_bid[g]),
      .i_flush_en  (flush_en),
      .i_flush_id  (flush_id),
      .o_back_vld  (w_back_vld[g]),
      .o_back_des  (w_back_des[g]),
      .o_issued_c  (w_issued[g]),
      .o_retired   (w_retired[g]),
      .o_flushed_c (w_flushed[g])
    );
  end

  assign ins_back_1_vld = w_back_vld[0];
  assign ins_back_1_des = w_back_des[0];
  assign ins_back_2_vld = w_back_vld[1];
  assign ins_back_2_des = w_back_des[1];
  assign ins_back_3_vld = w_back_vld[2];
  assign ins_back_3_des = w_back_des[2];
  assign ins_back_4_vld = w_back_vld[3];
  assign ins_back_4_des = w_back_des[3];

  // Net live-entry change across all lanes; wraps harmlessly mid-sum.
  always_comb begin
    w_cnt_next = ACC_W'(r_cnt);
    for (int k = 0; k < 4; k++) begin
      w_cnt_next = w_cnt_next + ACC_W'(w_issued[k]) - ACC_W'(w_retired[k])
                 - ACC_W'(w_flushed[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next[CNT_W-1:0];
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    w_cnt_next <= ACC_W'(CNT_MAX));

  assign inflight_cnt = r_cnt;
  assign idle         = (r_cnt == '0);

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Randomized scoreboard bench for exec_writeback_stage against a
// due-cycle model of each issued instruction.
module tb_exec_writeback_stage;

  localparam int LATS [4] = '{1, 1, 3, 4};

  typedef struct {
    int lane;
    int des;
    int bid;
    bit wb;
    int due;
    bit live;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld [4];
  logic [3:0] des [4];
  logic [3:0] op  [4];
  logic [2:0] bid [4];
  logic       flush_en = 1'b0;
  logic [2:0] flush_id = 3'd0;
  logic       back_vld [4];
  logic [3:0] back_des [4];
  logic [3:0] inflight_cnt;
  logic       idle;

  exp_t sb[$];
  int   edge_no  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  exec_writeback_stage #(.LAT1(1), .LAT2(1), .LAT3(3), .LAT4(4)) dut (
    .clk(clk), .rst(rst),
    .iq_out_1_vld(vld[0]), .iq_out_1_des(des[0]), .iq_out_1_op(op[0]), .iq_out_1_bid(bid[0]),
    .iq_out_2_vld(vld[1]), .iq_out_2_des(des[1]), .iq_out_2_op(op[1]), .iq_out_2_bid(bid[1]),
    .iq_out_3_vld(vld[2]), .iq_out_3_des(des[2]), .iq_out_3_op(op[2]), .iq_out_3_bid(bid[2]),
    .iq_out_4_vld(vld[3]), .iq_out_4_des(des[3]), .iq_out_4_op(op[3]), .iq_out_4_bid(bid[3]),
    .flush_en(flush_en), .flush_id(flush_id),
    .ins_back_1_vld(back_vld[0]), .ins_back_1_des(back_des[0]),
    .ins_back_2_vld(back_vld[1]), .ins_back_2_des(back_des[1]),
    .ins_back_3_vld(back_vld[2]), .ins_back_3_des(back_des[2]),
    .ins_back_4_vld(back_vld[3]), .ins_back_4_des(back_des[3]),
    .inflight_cnt(inflight_cnt), .idle(idle)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
  endtask

  // Monitor: compare DUT outputs after each edge, then retire finished entries.
  always @(posedge clk) begin
    int  exp_cnt;
    bit  ev;
    int  ed;
    edge_no++;
    #1;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rst_vld%0d", k + 1), int'(back_vld[k]), 0);
        chk($sformatf("rst_des%0d", k + 1), int'(back_des[k]), 0);
      end
      chk("rst_cnt", int'(inflight_cnt), 0);
      chk("rst_idle", int'(idle), 1);
    end else begin
      exp_cnt = 0;
      foreach (sb[i]) if (sb[i].live && sb[i].due >= edge_no) exp_cnt++;
      for (int k = 0; k < 4; k++) begin
        ev = 1'b0;
        ed = 0;
        foreach (sb[i]) begin
          if (sb[i].lane == k && sb[i].due == edge_no && sb[i].live && sb[i].wb) begin
            ev = 1'b1;
            ed = sb[i].des;
          end
        end
        chk($sformatf("vld%0d", k + 1), int'(back_vld[k]), int'(ev));
        if (ev) chk($sformatf("des%0d", k + 1), int'(back_des[k]), ed);
      end
      chk("inflight_cnt", int'(inflight_cnt), exp_cnt);
      chk("idle", int'(idle), int'(exp_cnt == 0));
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due <= edge_no) sb.delete(i);
      end
    end
  end

  // Record the cycle's stimulus in the model, let the edge happen, clear inputs.
  task automatic tick();
    int e;
    e = edge_no + 1;
    if (rst) begin
      if (flush_en) begin
        foreach (sb[i]) if (sb[i].bid == int'(flush_id)) sb[i].live = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) begin
          sb.push_back('{lane: k, des: int'(des[k]), bid: int'(bid[k]),
                         wb: (op[k] != 4'hF), due: e + LATS[k] - 1,
                         live: !(flush_en && bid[k] == flush_id)});
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    flush_en = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_lane(input int k, input int d, input int o, input int b);
    vld[k] = 1'b1;
    des[k] = 4'(d);
    op[k]  = 4'(o);
    bid[k] = 3'(b);
  endtask

  task automatic rand_cycle(input int flush_pct);
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 99) < 60)
        set_lane(k, int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 14)),
                 int'($urandom_range(0, 7)));
    end
    if ($urandom_range(0, 99) < flush_pct) begin
      flush_en = 1'b1;
      flush_id = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; des[k] = '0; op[k] = '0; bid[k] = '0;
    end
    // Reset held for 3 cycles under random issue traffic.
    for (int c = 0; c < 3; c++) begin
      rand_cycle(20);
      tick();
    end
    rst = 1'b1;
    idle_ticks(3);

    // Single MUL-lane latency.
    set_lane(2, 5, 2, 0);
    tick();
    idle_ticks(5);

    // Full load on all lanes, distinct destinations per lane.
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) set_lane(k, (c + 4 * k) % 16, 0, 0);
      tick();
    end
    idle_ticks(5);

    // Flush kills in-flight bid=2 entries but keeps the bid=3 one.
    set_lane(3, 1, 0, 2);
    tick();
    set_lane(3, 2, 0, 2);
    tick();
    set_lane(3, 3, 0, 3);
    flush_en = 1'b1;
    flush_id = 3'd2;
    tick();
    idle_ticks(6);

    // Same-edge flush of an incoming issue.
    set_lane(0, 9, 1, 4);
    flush_en = 1'b1;
    flush_id = 3'd4;
    tick();
    idle_ticks(2);

    // No-destination op still occupies a slot.
    set_lane(1, 6, 15, 1);
    tick();
    idle_ticks(3);

    // Reset mid-flight on the LD/ST lane discards the entry.
    set_lane(3, 7, 1, 1);
    tick();
    tick();
    assert_reset();
    idle_ticks(2);
    rst = 1'b1;
    idle_ticks(6);

    // Random traffic with occasional flushes and one mid-run reset.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        assert_reset();
        idle_ticks(2);
        rst = 1'b1;
      end
      rand_cycle(15);
      tick();
    end
    idle_ticks(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
